// File: rtl/uart_tx_if.sv
// CPU-facing bus of the memory-mapped UART transmitter.
//   load : write strobe (master -> slave)
//   in   : 16-bit write data, only the low byte is sent (master -> slave)
//   TX   : serial line, idle high (slave -> master)
//   out  : 16-bit status word, bit 15 = busy (slave -> master)
interface uart_tx_if;
    localparam int unsigned WORD_W = 16;

    logic              load;
    logic [WORD_W-1:0] in;
    logic              TX;
    logic [WORD_W-1:0] out;

    modport master (output load, in, input TX, out);
    modport slave  (input load, in, output TX, out);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter for the Hack computer.
// A load latches in[DATA_BITS-1:0] and sends start, data LSB first, stop.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_if.slave (load/in from the CPU, TX/out back to it)
module uart_tx #(
    parameter int unsigned BAUD_DIV  = 217,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_tx_if.slave   bus
);
    localparam int unsigned WORD_W = 16;
    localparam int unsigned SH_W   = DATA_BITS + 2;
    localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
    localparam int unsigned BITS_W = $clog2(DATA_BITS + 2);
    localparam logic [BAUD_W-1:0] BAUD_TC  = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BITS_W-1:0] LAST_BIT = BITS_W'(DATA_BITS + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    // Frame word {data, start, idle-one}; the idle-one in bit 0 is never
    // observed on the line, so only bits [SH_W-1:1] are stored.
    logic [SH_W-1:1]     sh_q, sh_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BITS_W-1:0]   bits_q, bits_d;
    logic                tick_c;
    logic                unused_in_hi;

    assign unused_in_hi = ^bus.in[WORD_W-1:DATA_BITS];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '1;
            baud_q  <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            baud_q  <= baud_d;
            bits_q  <= bits_d;
        end
    end

    assign tick_c = (state_q == ST_BUSY) && (baud_q == BAUD_TC);

    // Next state: load restarts the frame and wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        baud_d  = baud_q;
        bits_d  = bits_q;

        if (bus.load) begin
            state_d = ST_BUSY;
            sh_d    = {bus.in[DATA_BITS-1:0], 1'b0};
            baud_d  = '0;
            bits_d  = '0;
        end else if (state_q == ST_BUSY) begin
            if (tick_c) begin
                baud_d = '0;
                bits_d = BITS_W'(bits_q + 1'b1);
                sh_d   = {1'b1, sh_q[SH_W-1:2]};
                if (bits_q == LAST_BIT) begin
                    state_d = ST_IDLE;
                end
            end else begin
                baud_d = BAUD_W'(baud_q + 1'b1);
            end
        end
    end

    assign bus.TX  = sh_q[1];
    assign bus.out = {state_q == ST_BUSY, 15'd0};
endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
    localparam int BIT_T   = 217;
    localparam int FRAME_T = 2170;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if bus();

    uart_tx #(.BAUD_DIV(217), .DATA_BITS(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference: remember the last accepted load edge and its byte; the
    // line level and status follow from elapsed clocks divided by the bit time.
    bit          act = 1'b0;
    longint      cyc = 0;
    longint      e0 = 0;
    logic [7:0]  mdata = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act <= 1'b0;
        end else begin
            if (bus.load) begin
                act   <= 1'b1;
                e0    <= cyc;
                mdata <= bus.in[7:0];
            end
            cyc <= cyc + 1;
        end
    end

    function automatic longint elapsed();
        return cyc - 1 - e0;
    endfunction

    function automatic logic exp_tx();
        longint d;
        longint idx;
        if (!act) return 1'b1;
        d = elapsed();
        idx = d / BIT_T;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return mdata[idx-1];
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_out();
        if (act && elapsed() < FRAME_T) return 16'h8000;
        return 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    endtask

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("tx_model", {15'd0, bus.TX}, {15'd0, exp_tx()});
            chk("out_model", bus.out, exp_out());
        end
    end

    // Strobe load for one edge; returns at the negedge after the load edge.
    task automatic do_load(input logic [15:0] v);
        bus.load = 1'b1;
        bus.in   = v;
        @(negedge clk);
        bus.load = 1'b0;
        bus.in   = 16'($urandom);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Literal mid-bit checks of a whole frame, starting right after the load edge.
    task automatic check_frame_lit(input string tag, input logic [9:0] pat);
        int cur = 0;
        for (int j = 0; j < 10; j++) begin
            wait_cyc(BIT_T * j + 108 - cur);
            cur = BIT_T * j + 108;
            chk({tag, "_bit"}, {15'd0, bus.TX}, {15'd0, pat[j]});
        end
        wait_cyc(FRAME_T - 1 - cur);
        chk({tag, "_busy_last"}, bus.out, 16'h8000);
        wait_cyc(1);
        chk({tag, "_idle_after"}, bus.out, 16'h0000);
        chk({tag, "_tx_after"}, {15'd0, bus.TX}, 16'h0001);
    endtask

    initial begin
        bus.load = 1'b0;
        bus.in   = 16'h0000;
        wait_cyc(3);
        chk("reset_tx", {15'd0, bus.TX}, 16'h0001);
        chk("reset_out", bus.out, 16'h0000);
        rst_n = 1'b1;

        // Idle: model compares every cycle.
        wait_cyc(1000);
        chk("idle_tx", {15'd0, bus.TX}, 16'h0001);

        // 0xA5 LSB first: 0 | 1 0 1 0 0 1 0 1 | 1 (pattern bit j = level of bit j)
        do_load(16'h00A5);
        chk("a5_start", {15'd0, bus.TX}, 16'h0000);
        chk("a5_busy", bus.out, 16'h8000);
        check_frame_lit("a5", 10'b11_0100_1010);
        wait_cyc(100);

        // Upper byte ignored; 0x3C LSB first: 0 | 0 0 1 1 1 1 0 0 | 1
        do_load(16'hFF3C);
        check_frame_lit("3c", 10'b10_0111_1000);
        wait_cyc(100);

        // Random frames spaced 4000 clocks.
        for (int k = 0; k < 3; k++) begin
            do_load(16'($urandom));
            wait_cyc(3999);
        end

        // Restart mid-frame at E0+1000.
        do_load(16'h0055);
        wait_cyc(999);
        do_load(16'h00F0);
        chk("restart_start", {15'd0, bus.TX}, 16'h0000);
        wait_cyc(FRAME_T - 1);
        chk("restart_busy_last", bus.out, 16'h8000);
        wait_cyc(1);
        chk("restart_idle", bus.out, 16'h0000);
        wait_cyc(50);

        // Asynchronous reset mid-frame.
        do_load(16'h0000);
        wait_cyc(500);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", {15'd0, bus.TX}, 16'h0001);
        chk("async_rst_out", bus.out, 16'h0000);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        do_load(16'($urandom));
        wait_cyc(FRAME_T + 20);

        // Back-to-back: reload on exactly the frame-end edge.
        do_load(16'h0081);
        wait_cyc(FRAME_T - 1);
        chk("b2b_busy_before", bus.out, 16'h8000);
        do_load(16'h007E);
        chk("b2b_busy_at_edge", bus.out, 16'h8000);
        chk("b2b_start", {15'd0, bus.TX}, 16'h0000);
        wait_cyc(FRAME_T + 10);

        // load held for several edges; frame runs from the last one.
        bus.load = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in = 16'($urandom);
            @(negedge clk);
        end
        bus.load = 1'b0;
        wait_cyc(FRAME_T + 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
